// File: rtl/tennis_pkg.sv
// Shared types and constants for the tennis score keeper.
package tennis_pkg;

    // Game-level scoring states
    typedef enum logic [2:0] {
        PLAY  = 3'd0,
        DEUCE = 3'd1,
        ADV_A = 3'd2,
        ADV_B = 3'd3,
        OVER  = 3'd4
    } state_t;

    // Internal point codes
    localparam logic [1:0] PT_0  = 2'd0;
    localparam logic [1:0] PT_15 = 2'd1;
    localparam logic [1:0] PT_30 = 2'd2;
    localparam logic [1:0] PT_40 = 2'd3;

    // BCD display codes
    localparam logic [7:0] DISP_00 = 8'h00;
    localparam logic [7:0] DISP_15 = 8'h15;
    localparam logic [7:0] DISP_30 = 8'h30;
    localparam logic [7:0] DISP_40 = 8'h40;
    localparam logic [7:0] DISP_AD = 8'hAD;

    // Match winner codes
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_A    = 2'b01;
    localparam logic [1:0] WIN_B    = 2'b10;

endpackage

// File: rtl/tennis_point_disp.sv
// Combinational map from one player's point code plus advantage/deuce
// flags to the two-digit BCD display value.
module tennis_point_disp
    import tennis_pkg::*;
(
    input  logic [1:0] pt,
    input  logic       adv,
    input  logic       in_deuce,
    output logic [7:0] disp
);

    // Advantage overrides deuce, deuce overrides the raw point code
    always_comb begin
        disp = DISP_00;
        if (adv) begin
            disp = DISP_AD;
        end else if (in_deuce) begin
            disp = DISP_40;
        end else begin
            case (pt)
                PT_0:    disp = DISP_00;
                PT_15:   disp = DISP_15;
                PT_30:   disp = DISP_30;
                default: disp = DISP_40;
            endcase
        end
    end

endmodule

// File: rtl/tennis_score_keeper.sv
// Tennis score keeper: turns per-player point pulses into game/match
// scoring with registered display, game count, server and winner outputs.
module tennis_score_keeper
    import tennis_pkg::*;
#(
    parameter int GAMES_TO_WIN = 6,
    parameter int GW           = 4
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic          pt_a,
    input  logic          pt_b,
    input  logic          clear,
    output logic [7:0]    disp_a,
    output logic [7:0]    disp_b,
    output logic [GW-1:0] games_a,
    output logic [GW-1:0] games_b,
    output logic          server,
    output logic          deuce,
    output logic          game_won,
    output logic          match_over,
    output logic [1:0]    winner,
    output logic          conflict
);

    localparam logic [GW-1:0] GAMES_LIMIT = GW'(GAMES_TO_WIN);

    // Scoring state
    state_t        r_state;
    logic [1:0]    r_pa;
    logic [1:0]    r_pb;
    logic [GW-1:0] r_games_a;
    logic [GW-1:0] r_games_b;
    logic          r_server;
    logic [1:0]    r_winner;

    // Registered display/status outputs
    logic [7:0]    r_disp_a;
    logic [7:0]    r_disp_b;
    logic          r_deuce;
    logic          r_game_won;
    logic          r_match_over;
    logic          r_conflict;

    // Next-state values
    state_t        w_state_next;
    logic [1:0]    w_pa_next;
    logic [1:0]    w_pb_next;
    logic [GW-1:0] w_games_a_next;
    logic [GW-1:0] w_games_b_next;
    logic          w_server_next;
    logic [1:0]    w_winner_next;
    logic          w_game_won_next;
    logic          w_conflict_next;
    logic          w_win_a;
    logic          w_win_b;
    logic [GW-1:0] w_games_a_inc;
    logic [GW-1:0] w_games_b_inc;
    logic [7:0]    w_disp_a;
    logic [7:0]    w_disp_b;

    assign w_games_a_inc = r_games_a + 1'b1;
    assign w_games_b_inc = r_games_b + 1'b1;

    // Next-state logic: clear, then match over, then conflict, then single point
    always_comb begin
        w_state_next    = r_state;
        w_pa_next       = r_pa;
        w_pb_next       = r_pb;
        w_games_a_next  = r_games_a;
        w_games_b_next  = r_games_b;
        w_server_next   = r_server;
        w_winner_next   = r_winner;
        w_game_won_next = 1'b0;
        w_conflict_next = 1'b0;
        w_win_a         = 1'b0;
        w_win_b         = 1'b0;

        if (clear) begin
            w_state_next   = PLAY;
            w_pa_next      = PT_0;
            w_pb_next      = PT_0;
            w_games_a_next = '0;
            w_games_b_next = '0;
            w_server_next  = 1'b0;
            w_winner_next  = WIN_NONE;
        end else if (r_state == OVER) begin
            // Match finished: every point is ignored until clear/reset
        end else if (pt_a && pt_b) begin
            w_conflict_next = 1'b1;
        end else if (pt_a) begin
            case (r_state)
                PLAY: begin
                    if (r_pa == PT_40) begin
                        w_win_a = 1'b1;
                    end else if (r_pa == PT_30 && r_pb == PT_40) begin
                        w_pa_next    = PT_40;
                        w_state_next = DEUCE;
                    end else begin
                        w_pa_next = r_pa + 2'd1;
                    end
                end
                DEUCE:   w_state_next = ADV_A;
                ADV_A:   w_win_a      = 1'b1;
                ADV_B:   w_state_next = DEUCE;
                default: w_state_next = r_state;
            endcase
        end else if (pt_b) begin
            case (r_state)
                PLAY: begin
                    if (r_pb == PT_40) begin
                        w_win_b = 1'b1;
                    end else if (r_pb == PT_30 && r_pa == PT_40) begin
                        w_pb_next    = PT_40;
                        w_state_next = DEUCE;
                    end else begin
                        w_pb_next = r_pb + 2'd1;
                    end
                end
                DEUCE:   w_state_next = ADV_B;
                ADV_B:   w_win_b      = 1'b1;
                ADV_A:   w_state_next = DEUCE;
                default: w_state_next = r_state;
            endcase
        end

        // Game completion: points reset, and either the match ends or serve changes
        if (w_win_a || w_win_b) begin
            w_game_won_next = 1'b1;
            w_pa_next       = PT_0;
            w_pb_next       = PT_0;
            w_state_next    = PLAY;
            if (w_win_a) begin
                w_games_a_next = w_games_a_inc;
            end else begin
                w_games_b_next = w_games_b_inc;
            end
            if (w_win_a && w_games_a_inc == GAMES_LIMIT) begin
                w_state_next  = OVER;
                w_winner_next = WIN_A;
            end else if (w_win_b && w_games_b_inc == GAMES_LIMIT) begin
                w_state_next  = OVER;
                w_winner_next = WIN_B;
            end else begin
                w_server_next = ~r_server;
            end
        end
    end

    // Display values are derived from the next state so they register alongside it
    tennis_point_disp u_disp_a (
        .pt       (w_pa_next),
        .adv      (w_state_next == ADV_A),
        .in_deuce (w_state_next == DEUCE || w_state_next == ADV_B),
        .disp     (w_disp_a)
    );

    tennis_point_disp u_disp_b (
        .pt       (w_pb_next),
        .adv      (w_state_next == ADV_B),
        .in_deuce (w_state_next == DEUCE || w_state_next == ADV_A),
        .disp     (w_disp_b)
    );

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= PLAY;
            r_pa         <= PT_0;
            r_pb         <= PT_0;
            r_games_a    <= '0;
            r_games_b    <= '0;
            r_server     <= 1'b0;
            r_winner     <= WIN_NONE;
            r_disp_a     <= DISP_00;
            r_disp_b     <= DISP_00;
            r_deuce      <= 1'b0;
            r_game_won   <= 1'b0;
            r_match_over <= 1'b0;
            r_conflict   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pa         <= w_pa_next;
            r_pb         <= w_pb_next;
            r_games_a    <= w_games_a_next;
            r_games_b    <= w_games_b_next;
            r_server     <= w_server_next;
            r_winner     <= w_winner_next;
            r_disp_a     <= w_disp_a;
            r_disp_b     <= w_disp_b;
            r_deuce      <= (w_state_next == DEUCE);
            r_game_won   <= w_game_won_next;
            r_match_over <= (w_state_next == OVER);
            r_conflict   <= w_conflict_next;
        end
    end

    assign disp_a     = r_disp_a;
    assign disp_b     = r_disp_b;
    assign games_a    = r_games_a;
    assign games_b    = r_games_b;
    assign server     = r_server;
    assign deuce      = r_deuce;
    assign game_won   = r_game_won;
    assign match_over = r_match_over;
    assign winner     = r_winner;
    assign conflict   = r_conflict;

endmodule
